// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared FSM encoding and sizing helpers for the shift-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  // Iteration counter width; one spare bit so WIDTH itself is representable.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mult_cond_neg.sv
// rtl/mult_cond_neg.sv - conditional two's-complement negator
module mult_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/shift_add_mult.sv
// rtl/shift_add_mult.sv - sequential shift-and-add multiplier, signed or unsigned, WIDTH-cycle latency
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = cnt_width(WIDTH);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("shift_add_mult: WIDTH %0d outside legal range 4..64", WIDTH);
  end

  state_t             state, state_next;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg_res;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_next, p_next;
  logic               accept, last_iter;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid & in_ready;
  assign last_iter = (state == ST_CALC) && (cnt == CW'(WIDTH - 1));

  mult_cond_neg #(.WIDTH(WIDTH)) u_neg_a (
    .din  (a),
    .neg  (signed_mode & a[WIDTH-1]),
    .dout (a_mag)
  );

  mult_cond_neg #(.WIDTH(WIDTH)) u_neg_b (
    .din  (b),
    .neg  (signed_mode & b[WIDTH-1]),
    .dout (b_mag)
  );

  mult_cond_neg #(.WIDTH(2*WIDTH)) u_neg_p (
    .din  (acc_next),
    .neg  (neg_res),
    .dout (p_next)
  );

  // Upper half accumulates; lower half starts as the multiplier and shifts out LSB-first.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (in_valid)  state_next = ST_CALC;
      ST_CALC: if (last_iter) state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      p       <= '0;
    end else if (accept) begin
      mcand   <= a_mag;
      acc     <= {{WIDTH{1'b0}}, b_mag};
      cnt     <= '0;
      neg_res <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == ST_CALC) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
      if (last_iter) begin
        p <= p_next;
      end
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb/tb_shift_add_mult.sv - scoreboard bench for shift_add_mult at WIDTH=32
module tb_shift_add_mult;

  localparam int WIDTH = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               signed_mode = 1'b0;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   a = '0;
  logic [WIDTH-1:0]   b = '0;
  logic               in_ready;
  logic               out_valid;
  logic [2*WIDTH-1:0] p;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*WIDTH-1:0] sb_q[$];

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .p           (p)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sm);
    longint sx, sy;
    if (sm) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'd0, x} * {32'd0, y};
  endfunction

  // One transaction: accept, watch latency, optionally stall the consumer or abort via reset.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_op,
                        input logic tsm, input logic [63:0] expv, input int hold, input int abort_at);
    int waited;
    int lat;
    logic [63:0] got;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_val({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    a           = ta;
    b           = tb_op;
    signed_mode = tsm;
    out_ready   = (hold == 0);
    @(posedge clk);
    sb_q.push_back(expv);
    @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 10) begin
        in_valid    = 1'b1;
        a           = ~ta;
        b           = tb_op + 32'd9;
        signed_mode = ~tsm;
      end
      if (lat == 11) begin
        in_valid = 1'b0;
        check_val({tag, "_calc_in_ready"}, 64'(in_ready), 64'd0);
      end
      if (lat == abort_at) begin
        rst = 1'b1;
        #1;
        check_val({tag, "_rst_out_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, "_rst_p"}, p, 64'd0);
        check_val({tag, "_rst_in_ready"}, 64'(in_ready), 64'd1);
        sb_q.delete();
        @(negedge clk);
        check_val({tag, "_rst_held_out_valid"}, 64'(out_valid), 64'd0);
        rst = 1'b0;
        return;
      end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'd32);
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
      got = '0;
    end else begin
      got = sb_q.pop_front();
      check_val({tag, "_p"}, p, got);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = ta ^ 32'h5A5A_5A5A;
      @(negedge clk);
      check_val({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      check_val({tag, "_stall_p"}, p, got);
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val({tag, "_release_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_release_in_ready"}, 64'(in_ready), 64'd1);
    check_val({tag, "_p_held"}, p, got);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    #1;
    check_val("reset_in_ready", 64'(in_ready), 64'd1);
    check_val("reset_out_valid", 64'(out_valid), 64'd0);
    check_val("reset_p", p, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op("u_3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0, -1);
    run_op("s_m3x7", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, -1);
    run_op("s_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, -1);
    run_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 10, -1);
    run_op("u_zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 0, -1);
    run_op("abort", 32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, 0, 15);
    run_op("after_rst_6x7", 32'd6, 32'd7, 1'b0, 64'd42, 0, -1);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'(k % 2);
      run_op("rand", ra, rb, rs, model(ra, rb, rs), k % 3, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
